program_counter_n: RTL
======================

Name: program_counter_n

Overview:
Parametrised program counter for the next-generation datapath. It generalises the fixed 2-bit ripple counter to a WIDTH-bit synchronous counter with the following additions:
- absolute jump load
- count enable
- sticky overflow flag
- DEPTH-entry hardware return-address stack for call/return

It sits between the control unit (which drives the En, Load, Call and Ret strobes) and instruction memory (which receives PC).

Parameters:
WIDTH, 2, bit width of PC and of all addresses
DEPTH, 4, number of return-address stack entries (at least 1)
RESET_VEC, 0, value PC takes on Reset (WIDTH bits)

Ports:
CLK  input  1  single system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
En  input  1  increment PC by 1 this cycle
Load  input  1  jump: PC <= Load_addr
Load_addr  input  WIDTH  jump/call target address
Call  input  1  push PC+1 onto the return stack, then PC <= Load_addr
Ret  input  1  pop the stack top into PC
PC  output  WIDTH  current program counter (registered)
Over  output  1  sticky: set when an increment wraps all-ones -> 0
Stack_full  output  1  stack holds DEPTH entries (combinational from count)
Stack_empty  output  1  stack holds 0 entries
Stack_err  output  1  one-cycle pulse on illegal Call (full) or Ret (empty)

Behaviour:
- Reset (sampled at a rising edge) overrides everything:
  - PC=RESET_VEC, Over=0, stack count=0, Stack_err=0.
  - Stack_empty=1 and Stack_full=0 (Stack_full=0 holds even if DEPTH=1).
  - Stack entry contents are don't-care.
- Reset mid-operation discards all pending stack contents. There are no partial effects.
- Per-cycle priority, highest first: Reset > Ret > Call > Load > En. Only the highest asserted command acts; lower ones are ignored that cycle.
- Idle (no command asserted): PC, Over and stack all hold. Stack_err=0.
- En: PC <= PC+1, computed modulo 2^WIDTH.
  - If PC was all-ones, PC becomes 0 and Over <= 1.
  - Over stays 1 until Reset. No other command clears it.
- Load: PC <= Load_addr. Over is unchanged.
- Call, stack not full:
  - stack[count] <= PC+1 (mod 2^WIDTH); count++.
  - PC <= Load_addr.
  - An all-ones PC pushes 0 and does not set Over.
- Call, stack full:
  - No push, PC holds.
  - Stack_err=1 for exactly the next cycle.
- Ret, stack not empty: PC <= stack[count-1]; count--.
- Ret, stack empty:
  - PC holds.
  - Stack_err=1 for the next cycle.
- Ret and Call in the same cycle: Ret wins, Call is ignored. This includes the case where the stack is full, so there is no error.
- Latency: every command takes effect on PC at the edge where it is sampled. PC is visible the following cycle, with no extra pipeline stage.
- Stack_err is registered: it is high during the cycle after the offending edge, and 0 otherwise.
- Stack_full and Stack_empty reflect the registered count in the same cycle.
- Count width is clog2(DEPTH+1). The count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package pc_pkg holds:
  - the command priority encoding as a localparam enum: CMD_NONE, CMD_INC, CMD_LOAD, CMD_CALL, CMD_RET;
  - the function clog2.
- One sub-module, pc_return_stack (LIFO):
  - parameters WIDTH and DEPTH;
  - ports CLK, Reset, push, pop, din, dout, full, empty.
- The top level owns the priority decode, the PC register, Over and Stack_err. It asserts push/pop only on legal operations.

Test Plan:
- Reset: hold Reset 2 cycles with En=1 -> PC=RESET_VEC=0, Over=0, Stack_empty=1, Stack_err=0. Release, then En for 3 cycles -> PC sequence 1,2,3.
- Wrap (WIDTH=2): En held 5 cycles from 0 -> PC 1,2,3,0,1. Over rises the cycle PC becomes 0 and stays 1. Load 2 -> PC=2, Over still 1. Reset -> Over=0.
- Nested call/return (WIDTH=4, DEPTH=2):
  - from PC=3, Call addr 8 -> PC=8, count=1;
  - Call addr 12 -> PC=12, Stack_full=1;
  - Ret -> PC=9; Ret -> PC=4, Stack_empty=1.
- Stack errors (DEPTH=2):
  - with the stack full, Call addr 5 -> PC unchanged, Stack_err=1 for one cycle, count=2;
  - with the stack empty, Ret -> PC unchanged, Stack_err pulse.
- Priority: Load=1, En=1, Load_addr=6 -> PC=6, not PC+1. Call and Ret together with 1 entry holding 7 -> PC=7, stack empty, no Stack_err. Reset asserted with Call -> PC=RESET_VEC, stack empty.
- Call from PC=all-ones (WIDTH=2, PC=3), Call addr 1 -> pushed value 0, Over stays 0. Ret -> PC=0.

Source files
------------

// File: rtl/program_counter_n_pkg.sv
// Shared definitions for the program counter: command priority encoding and
// the ceiling-log2 helper used to size the return-stack count.
package pc_pkg;

  // Listed lowest to highest priority. The top level decodes one command per cycle.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/program_counter_n_if.sv
// Bus between the control unit (master) and the program counter (slave).
interface program_counter_n_if #(
  parameter int WIDTH = 2
);
  logic             En;
  logic             Load;
  logic [WIDTH-1:0] Load_addr;
  logic             Call;
  logic             Ret;
  logic [WIDTH-1:0] PC;
  logic             Over;
  logic             Stack_full;
  logic             Stack_empty;
  logic             Stack_err;

  modport master (
    output En, Load, Load_addr, Call, Ret,
    input  PC, Over, Stack_full, Stack_empty, Stack_err
  );

  modport slave (
    input  En, Load, Load_addr, Call, Ret,
    output PC, Over, Stack_full, Stack_empty, Stack_err
  );
endinterface

// File: rtl/program_counter_n_return_stack.sv
// DEPTH-entry LIFO of return addresses. Entries are not reset; only the
// occupancy count is. The caller never pushes when full or pops when empty.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = IDX_W'(count);
  assign rd_idx = IDX_W'(count - CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (Reset)     count <= '0;
    else if (push) count <= count + CNT_W'(1);
    else if (pop)  count <= count - CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_idx] <= din;
  end

  // Read value is meaningless while empty; the caller only uses it on a legal pop.
  assign dout  = mem[rd_idx];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/program_counter_n.sv
// WIDTH-bit program counter with jump, count enable, sticky wrap flag and a
// hardware return-address stack for call/return.
module program_counter_n
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic               CLK,
  input logic               Reset,
  program_counter_n_if.slave bus
);
  cmd_e             cmd;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stack_top;
  logic             over_q;
  logic             over_d;
  logic             err_q;
  logic             err_d;

  always_comb begin
    cmd = CMD_NONE;
    if (bus.Ret)       cmd = CMD_RET;
    else if (bus.Call) cmd = CMD_CALL;
    else if (bus.Load) cmd = CMD_LOAD;
    else if (bus.En)   cmd = CMD_INC;
  end

  assign pc_inc = pc_q + WIDTH'(1);
  assign push   = (cmd == CMD_CALL) && !full;
  assign pop    = (cmd == CMD_RET) && !empty;

  always_comb begin
    pc_d   = pc_q;
    over_d = over_q;
    err_d  = 1'b0;
    case (cmd)
      CMD_INC: begin
        pc_d = pc_inc;
        if (pc_q == '1) over_d = 1'b1;
      end
      CMD_LOAD: pc_d = bus.Load_addr;
      CMD_CALL: begin
        if (full) err_d = 1'b1;
        else      pc_d  = bus.Load_addr;
      end
      CMD_RET: begin
        if (empty) err_d = 1'b1;
        else       pc_d  = stack_top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q   <= RESET_VEC;
      over_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      over_q <= over_d;
      err_q  <= err_d;
    end
  end

  pc_return_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .CLK  (CLK),
    .Reset(Reset),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .dout (stack_top),
    .full (full),
    .empty(empty)
  );

  assign bus.PC          = pc_q;
  assign bus.Over        = over_q;
  assign bus.Stack_err   = err_q;
  assign bus.Stack_full  = full;
  assign bus.Stack_empty = empty;

endmodule
